mult_test_sequencer: RTL and testbench

Autonomous test controller for the 16-bit multiplier test harness. On a `begin_test` pulse it generates a fixed-length series of operand pairs (two corner vectors, then LFSR vectors), starts the multiplier under test once per vector, waits on its `busy` handshake with a timeout, and checks the `results_match` flag from the gold-multiplier compare stage. It counts passes, stops on the first failure, and drives a 5-bit status code plus the operands to the seven-segment display path.

---
 rtl/mult_test_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_mult_test_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_test_sequencer.sv
// -----------------------------------------------------------------------------
// mult_test_sequencer
//
// Autonomous test controller for the 16-bit multiplier harness. A begin_test
// pulse launches a run of NUM_TESTS vectors (all-zero, all-ones, then LFSR
// pairs). Each vector starts the multiplier under test, waits for its busy
// handshake under a timeout, and checks the gold-compare flag. The run stops
// on the first failure and reports a status code for the display path.
//
// Ports
//   clock          single clock
//   reset_n        asynchronous active-low reset
//   begin_test     one-cycle start pulse (debounced upstream)
//   inject_error   one-cycle pulse, forces a mismatch on the next check
//   busy           busy flag of the multiplier under test
//   results_match  test result equals gold result
//   opA, opB       operands driven to both multipliers
//   mult_start     one-cycle start pulse to the multiplier under test
//   status_out     display status code
//   test_index     index of the current or last vector (0-based)
//   pass_count     vectors passed in the current or last run
//   done           high in PASS or FAIL
//
// State table
//   state      | meaning
//   S_IDLE     | after reset, waiting for begin_test
//   S_LOAD     | drive operands for vector test_index
//   S_START    | mult_start high for this cycle, arm the timeout timer
//   S_WAIT_HI  | waiting for busy to rise
//   S_WAIT_LO  | waiting for busy to fall
//   S_CHECK    | sample results_match / armed error
//   S_PASS     | all vectors passed, last vector held
//   S_FAIL     | failing vector held, status holds the failure cause
// -----------------------------------------------------------------------------
module mult_test_sequencer #(
  parameter int unsigned NUM_TESTS = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        begin_test,
  input  logic        inject_error,
  input  logic        busy,
  input  logic        results_match,
  output logic [15:0] opA,
  output logic [15:0] opB,
  output logic        mult_start,
  output logic [4:0]  status_out,
  output logic [7:0]  test_index,
  output logic [7:0]  pass_count,
  output logic        done
);

  localparam logic [4:0] ST_IDLE          = 5'h10;
  localparam logic [4:0] ST_RUNNING       = 5'h11;
  localparam logic [4:0] ST_PASS          = 5'h12;
  localparam logic [4:0] ST_FAIL_MISMATCH = 5'h13;
  localparam logic [4:0] ST_FAIL_TIMEOUT  = 5'h14;

  localparam logic [7:0]  LAST_INDEX = 8'(NUM_TESTS - 1);

  // The down-counter is loaded on the START cycle and the terminal count is
  // tested on every wait cycle. Loading TIMEOUT-2 places the FAIL entry
  // exactly TIMEOUT clock edges after the edge that raised mult_start.
  localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_a;
  logic [15:0] lfsr_b;
  logic [15:0] timer;
  logic        error_armed;
  logic        mismatch;
  logic        timer_tc;

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Two steps per LFSR vector: opA gets the first, opB the second.
  assign lfsr_a = lfsr_step(lfsr);
  assign lfsr_b = lfsr_step(lfsr_a);

  // An injection arriving in the CHECK cycle itself still fails that check.
  assign mismatch = !results_match || error_armed || inject_error;
  assign timer_tc = (timer == 16'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      lfsr        <= LFSR_SEED;
      opA         <= 16'h0000;
      opB         <= 16'h0000;
      mult_start  <= 1'b0;
      status_out  <= ST_IDLE;
      test_index  <= 8'd0;
      pass_count  <= 8'd0;
      done        <= 1'b0;
      error_armed <= 1'b0;
      timer       <= 16'd0;
    end else begin
      mult_start <= 1'b0;

      if (inject_error) begin
        error_armed <= 1'b1;
      end

      case (state)
        S_IDLE, S_PASS, S_FAIL: begin
          if (begin_test) begin
            test_index <= 8'd0;
            pass_count <= 8'd0;
            lfsr       <= LFSR_SEED;
            status_out <= ST_RUNNING;
            done       <= 1'b0;
            state      <= S_LOAD;
          end
        end

        S_LOAD: begin
          case (test_index)
            8'd0: begin
              opA <= 16'h0000;
              opB <= 16'h0000;
            end
            8'd1: begin
              opA <= 16'hFFFF;
              opB <= 16'hFFFF;
            end
            default: begin
              opA  <= lfsr_a;
              opB  <= lfsr_b;
              lfsr <= lfsr_b;
            end
          endcase
          mult_start <= 1'b1;
          state      <= S_START;
        end

        S_START: begin
          timer <= TIMER_LOAD;
          state <= S_WAIT_HI;
        end

        // Timeout takes priority over a busy transition in the same cycle.
        S_WAIT_HI: begin
          if (timer_tc) begin
            status_out <= ST_FAIL_TIMEOUT;
            done       <= 1'b1;
            state      <= S_FAIL;
          end else begin
            timer <= timer - 16'd1;
            if (busy) begin
              state <= S_WAIT_LO;
            end
          end
        end

        S_WAIT_LO: begin
          if (timer_tc) begin
            status_out <= ST_FAIL_TIMEOUT;
            done       <= 1'b1;
            state      <= S_FAIL;
          end else begin
            timer <= timer - 16'd1;
            if (!busy) begin
              state <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          if (mismatch) begin
            error_armed <= 1'b0;
            status_out  <= ST_FAIL_MISMATCH;
            done        <= 1'b1;
            state       <= S_FAIL;
          end else begin
            pass_count <= pass_count + 8'd1;
            if (test_index == LAST_INDEX) begin
              status_out <= ST_PASS;
              done       <= 1'b1;
              state      <= S_PASS;
            end else begin
              test_index <= test_index + 8'd1;
              state      <= S_LOAD;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_test_sequencer.sv
`timescale 1ns/1ps
module tb_mult_test_sequencer;

  localparam int N = 16;
  localparam int T = 64;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        begin_test = 1'b0;
  logic        inject_error = 1'b0;
  logic        busy = 1'b0;
  logic        results_match = 1'b1;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        mult_start;
  logic [4:0]  status_out;
  logic [7:0]  test_index;
  logic [7:0]  pass_count;
  logic        done;

  int checks = 0;
  int failures = 0;
  int starts_seen = 0;

  logic [15:0] exp_a [N];
  logic [15:0] exp_b [N];

  mult_test_sequencer #(
    .NUM_TESTS(N),
    .LFSR_SEED(SEED),
    .TIMEOUT(T)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .begin_test(begin_test),
    .inject_error(inject_error),
    .busy(busy),
    .results_match(results_match),
    .opA(opA),
    .opB(opB),
    .mult_start(mult_start),
    .status_out(status_out),
    .test_index(test_index),
    .pass_count(pass_count),
    .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mult_start === 1'b1) starts_seen <= starts_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift left, feed back the parity of the tapped bits (16,14,13,11).
  function automatic logic [15:0] model_next(input logic [15:0] s);
    return (s << 1) | 16'(^(s & 16'hB400));
  endfunction

  task automatic build_model();
    logic [15:0] s;
    s = SEED;
    for (int i = 0; i < N; i++) begin
      if (i == 0) begin
        exp_a[i] = 16'h0000; exp_b[i] = 16'h0000;
      end else if (i == 1) begin
        exp_a[i] = 16'hFFFF; exp_b[i] = 16'hFFFF;
      end else begin
        s = model_next(s); exp_a[i] = s;
        s = model_next(s); exp_b[i] = s;
      end
    end
  endtask

  task automatic pulse_begin();
    begin_test = 1'b1;
    @(negedge clock);
    begin_test = 1'b0;
  endtask

  task automatic wait_start(output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int k = 0; k < 12; k++) begin
      if (mult_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
      waited++;
    end
    check("mult_start_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic do_vector(input int i, input int len, input bit match,
                           input bit inj_busy, input bit inj_check, input bit bt_busy,
                           output bit ok);
    int waited;
    wait_start(ok, waited);
    if (!ok) return;
    check($sformatf("opA[%0d]", i), opA, exp_a[i]);
    check($sformatf("opB[%0d]", i), opB, exp_b[i]);
    check($sformatf("index[%0d]", i), test_index, i);
    check($sformatf("pass_before[%0d]", i), pass_count, i);
    check($sformatf("status_run[%0d]", i), status_out, 5'h11);
    if (i == 2) begin
      check("vec2_opA", opA, 16'h59C3);
      check("vec2_opB", opB, 16'hB387);
    end
    busy = 1'b1;
    for (int j = 0; j < len; j++) begin
      @(negedge clock);
      inject_error = inj_busy && (j == 0);
      begin_test   = bt_busy && (j == 0);
    end
    busy = 1'b0;
    inject_error = 1'b0;
    begin_test = 1'b0;
    results_match = match;
    @(negedge clock);
    inject_error = inj_check;
    @(negedge clock);
    inject_error = 1'b0;
    results_match = 1'b1;
  endtask

  // Runs one full sequence and compares the final report with the outcome
  // predicted from the run configuration: the earliest vector that is forced
  // to mismatch (or is pre-armed) fails, otherwise every vector passes.
  task automatic run_test(input int fail_at, input int inj_busy_at, input int inj_check_at,
                          input int bt_at, input bit pre_armed, input int fixed_len);
    int  k;
    int  len;
    int  base;
    int  waited;
    bit  ok;
    k = N;
    if (pre_armed) k = 0;
    if (fail_at >= 0 && fail_at < k) k = fail_at;
    if (inj_busy_at >= 0 && inj_busy_at < k) k = inj_busy_at;
    if (inj_check_at >= 0 && inj_check_at < k) k = inj_check_at;
    base = starts_seen;

    pulse_begin();
    check("run_status", status_out, 5'h11);
    check("run_done_low", 32'(done), 32'd0);
    check("run_index_clear", test_index, 8'd0);
    check("run_pass_clear", pass_count, 8'd0);
    check("load_no_start", 32'(mult_start), 32'd0);
    wait_start(ok, waited);
    check("start_latency", waited, 1);

    for (int i = 0; i < N; i++) begin
      len = (fixed_len > 0) ? fixed_len : int'($urandom_range(2, 40));
      do_vector(i, len, (i != fail_at), (i == inj_busy_at), (i == inj_check_at),
                (i == bt_at), ok);
      if (!ok || i == k) break;
      check($sformatf("pass_after[%0d]", i), pass_count, i + 1);
    end

    wait_done(ok);
    if (k == N) begin
      check("final_status", status_out, 5'h12);
      check("final_pass", pass_count, N);
      check("final_index", test_index, N - 1);
      check("final_opA", opA, exp_a[N-1]);
      check("final_opB", opB, exp_b[N-1]);
      check("start_count", starts_seen - base, N);
    end else begin
      check("final_status", status_out, 5'h13);
      check("final_pass", pass_count, k);
      check("final_index", test_index, k);
      check("final_opA", opA, exp_a[k]);
      check("final_opB", opB, exp_b[k]);
      check("start_count", starts_seen - base, k + 1);
    end
    check("final_done", 32'(done), 32'd1);
    @(negedge clock);
    check("final_hold_status", status_out, (k == N) ? 5'h12 : 5'h13);
    check("final_no_start", 32'(mult_start), 32'd0);
  endtask

  // mode 0: busy never rises; 1: busy stuck high; 2: busy falls on the deadline cycle.
  task automatic timeout_test(input int mode);
    bit ok;
    int waited;
    pulse_begin();
    wait_start(ok, waited);
    if (mode != 0) busy = 1'b1;
    for (int j = 1; j < T; j++) begin
      @(negedge clock);
      if (mode == 2 && j == T - 1) busy = 1'b0;
    end
    check($sformatf("to%0d_done_before", mode), 32'(done), 32'd0);
    check($sformatf("to%0d_status_before", mode), status_out, 5'h11);
    @(negedge clock);
    check($sformatf("to%0d_done", mode), 32'(done), 32'd1);
    check($sformatf("to%0d_status", mode), status_out, 5'h14);
    check($sformatf("to%0d_index", mode), test_index, 8'd0);
    check($sformatf("to%0d_pass", mode), pass_count, 8'd0);
    busy = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_opA"}, opA, 16'h0000);
    check({tag, "_opB"}, opB, 16'h0000);
    check({tag, "_start"}, 32'(mult_start), 32'd0);
    check({tag, "_status"}, status_out, 5'h10);
    check({tag, "_index"}, test_index, 8'd0);
    check({tag, "_pass"}, pass_count, 8'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit ok;
    int waited;
    int base;
    int r;

    build_model();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("por");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_values("idle");

    // Nominal run with a 17-cycle multiplier.
    run_test(-1, -1, -1, -1, 1'b0, 17);

    // Forced mismatch on vector 5, then at a random vector.
    run_test(5, -1, -1, -1, 1'b0, 0);
    r = int'($urandom_range(2, N - 1));
    run_test(r, -1, -1, -1, 1'b0, 0);

    // Injection while not running fails vector 0; the next run is clean.
    inject_error = 1'b1;
    @(negedge clock);
    inject_error = 1'b0;
    repeat (3) @(negedge clock);
    run_test(-1, -1, -1, -1, 1'b1, 0);
    run_test(-1, -1, -1, -1, 1'b0, 0);

    // Injection during a wait, and injection landing on the CHECK cycle itself.
    run_test(-1, int'($urandom_range(0, N - 1)), -1, -1, 1'b0, 0);
    run_test(-1, -1, int'($urandom_range(0, N - 1)), -1, 1'b0, 0);

    // Timeout variants.
    timeout_test(0);
    timeout_test(1);
    timeout_test(2);

    // Longest busy that still beats the deadline.
    run_test(-1, -1, -1, -1, 1'b0, T - 2);

    // begin_test while running is ignored; the following run starts from PASS.
    run_test(-1, -1, -1, 2, 1'b0, 0);
    run_test(-1, -1, -1, -1, 1'b0, 0);

    // Asynchronous reset during WAIT_LO of vector 3.
    pulse_begin();
    for (int i = 0; i < 3; i++) begin
      do_vector(i, 10, 1'b1, 1'b0, 1'b0, 1'b0, ok);
    end
    wait_start(ok, waited);
    check("rst_vec3_opA", opA, exp_a[3]);
    busy = 1'b1;
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    busy = 1'b0;
    base = starts_seen;
    repeat (30) @(negedge clock);
    check("rst_no_start", starts_seen - base, 0);
    check_reset_values("rst_idle");
    run_test(-1, -1, -1, -1, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
